axis_fork: RTL

AXIS_FORK -- requirements
Module: axis_fork

---
 rtl/axis_fork_pkg.sv | 22 ++
 rtl/axi4s.sv | 11 +
 rtl/axis_fork.sv | 86 ++++++++
 3 files changed

// File: rtl/axis_fork_pkg.sv
// Shared AXIS definitions: the fork pending-state encoding and helpers
// that decode which output copies are still owed.
package axis_fork_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BOTH  = 2'd1,
      ONLY1 = 2'd2,
      ONLY2 = 2'd3
   } fork_state_e;

   // out1 still owes a copy of the held beat
   function automatic logic owes_out1(input fork_state_e s);
      return (s == BOTH) || (s == ONLY1);
   endfunction

   // out2 still owes a copy of the held beat
   function automatic logic owes_out2(input fork_state_e s);
      return (s == BOTH) || (s == ONLY2);
   endfunction

endpackage

// File: rtl/axi4s.sv
// Minimal AXI4-Stream bundle: data, valid, ready.
interface AXI4S #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport Master (output data, output valid, input ready);
   modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/axis_fork.sv
// Two-way AXI4-Stream fork. One shared data register feeds both outputs;
// a small pending-state machine tracks which copies are still owed. A new
// beat is taken only when every owed copy leaves in the same cycle, so a
// copy is never overwritten before it is delivered.
module axis_fork
   import axis_fork_pkg::*;
#(
   parameter int CNT_WIDTH = 32,
   parameter int DATA_W    = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 en,
   AXI4S.Slave                  in,
   AXI4S.Master                 out1,
   AXI4S.Master                 out2,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] beat_count
);

   fork_state_e          state_q, state_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic pend1, pend2;
   logic slot1_free, slot2_free;
   logic in_ready;
   logic fire_in, fire1, fire2;

   assign pend1      = owes_out1(state_q);
   assign pend2      = owes_out2(state_q);
   assign slot1_free = !pend1 || out1.ready;
   assign slot2_free = !pend2 || out2.ready;

   // Gating with resetn keeps intake closed during a reset cycle.
   assign in_ready   = resetn && en && slot1_free && slot2_free;
   assign fire_in    = in.valid && in_ready;
   assign fire1      = pend1 && out1.ready;
   assign fire2      = pend2 && out2.ready;

   assign in.ready   = in_ready;
   assign out1.valid = pend1;
   assign out2.valid = pend2;
   assign out1.data  = data_q;
   assign out2.data  = data_q;
   assign busy       = (state_q != EMPTY);
   assign beat_count = count_q;

   // Next state: an input fire always reloads and owes both copies;
   // otherwise retire whichever copies fired this cycle.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      if (fire_in) begin
         state_d = BOTH;
         data_d  = in.data;
         count_d = count_q + CNT_WIDTH'(1);
      end else begin
         case (state_q)
            BOTH: begin
               if (fire1 && fire2) state_d = EMPTY;
               else if (fire1)     state_d = ONLY2;
               else if (fire2)     state_d = ONLY1;
            end
            ONLY1:   if (fire1) state_d = EMPTY;
            ONLY2:   if (fire2) state_d = EMPTY;
            default: state_d = state_q;
         endcase
      end
   end

   // State, data and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= EMPTY;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

endmodule
